alarm_button_pio: RTL and testbench



---
 rtl/alarm_button_pio_if.sv | 28 ++
 rtl/alarm_button_pio.sv | 128 ++++++++++++
 tb/tb_alarm_button_pio.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/alarm_button_pio_if.sv
// -----------------------------------------------------------------------------
// alarm_button_pio_if
// Avalon-MM slave bus bundle for the alarm clock push-button PIO.
//   address    : register select (word offset), master -> slave
//   chipselect : slave select, master -> slave
//   write_n    : write strobe, active-low, master -> slave
//   writedata  : 32-bit write data, master -> slave
//   readdata   : 32-bit read data (zero wait states), slave -> master
//   irq        : level interrupt, active-high, slave -> master
// -----------------------------------------------------------------------------
interface alarm_button_pio_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq
    );
endinterface

// File: rtl/alarm_button_pio.sv
// -----------------------------------------------------------------------------
// alarm_button_pio
// Avalon-MM input PIO for the alarm clock push-buttons. Every button pin is
// synchronized, debounced, and exposed as a level register (DATA) plus a
// sticky press-capture register (EDGECAPTURE). A masked level interrupt
// tells the CPU that a button has been pressed.
//
// Ports:
//   clk      : system clock
//   reset_n  : asynchronous active-low reset
//   bus      : Avalon-MM slave (address, chipselect, write_n, writedata,
//              readdata, irq)
//   in_port  : raw asynchronous button pins, WIDTH bits
//
// Register map (word offset):
//   0 DATA        : debounced pressed level, read-only
//   1 IRQMASK     : read/write interrupt enable per button
//   2 reserved    : reads 0, writes ignored
//   3 EDGECAPTURE : sticky press flags, write 1 to clear
// -----------------------------------------------------------------------------
module alarm_button_pio #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    alarm_button_pio_if.slave    bus,
    input  logic [WIDTH-1:0]     in_port
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    // Pin level of a released button; the synchronizer resets to it so no
    // spurious press is seen coming out of reset.
    localparam logic [WIDTH-1:0] RELEASED = (ACTIVE_LOW != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    logic [WIDTH-1:0] pressed_raw;
    logic [WIDTH-1:0] edge_clr;
    logic             wr;
    logic [31:0]      rdata;
    logic             unused_wdata;

    // Bits of writedata above WIDTH carry no meaning for this block.
    assign unused_wdata = ^bus.writedata;

    always_comb begin
        sync1_d     = in_port;
        sync2_d     = sync1_q;
        pressed_raw = sync2_q ^ RELEASED;

        // Debounce: a bit must disagree with its stable level for
        // DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
        stable_d = stable_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (pressed_raw[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                stable_d[i] = pressed_raw[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end

        wr = bus.chipselect && !bus.write_n;

        mask_d = mask_q;
        if (wr && bus.address == 2'd1) begin
            mask_d = bus.writedata[WIDTH-1:0];
        end

        edge_clr = '0;
        if (wr && bus.address == 2'd3) begin
            edge_clr = bus.writedata[WIDTH-1:0];
        end

        // The press term is ORed in after the clear so a press on the same
        // edge as a software clear is never lost.
        edge_cap_d = (edge_cap_q & ~edge_clr) | (stable_d & ~stable_q);

        rdata = '0;
        if (bus.chipselect) begin
            case (bus.address)
                2'd0:    rdata[WIDTH-1:0] = stable_q;
                2'd1:    rdata[WIDTH-1:0] = mask_q;
                2'd3:    rdata[WIDTH-1:0] = edge_cap_q;
                default: rdata            = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q    <= RELEASED;
            sync2_q    <= RELEASED;
            stable_q   <= '0;
            mask_q     <= '0;
            edge_cap_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            stable_q   <= stable_d;
            mask_q     <= mask_d;
            edge_cap_q <= edge_cap_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign bus.readdata = rdata;
    // Registered-only source: no path from the bus inputs to irq.
    assign bus.irq      = |(edge_cap_q & mask_q);

endmodule

// File: tb/tb_alarm_button_pio.sv
// -----------------------------------------------------------------------------
// tb_alarm_button_pio
// Directed bench for alarm_button_pio with WIDTH=4, DEBOUNCE_CYCLES=4,
// ACTIVE_LOW=1. Inputs change 1 ns after a rising edge; outputs are sampled
// a few ns later, well away from the next rising edge.
// -----------------------------------------------------------------------------
module tb_alarm_button_pio;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] in_port;
    int         n_tests = 0;
    int         n_failed = 0;

    alarm_button_pio_if bus ();

    alarm_button_pio #(
        .WIDTH(4),
        .DEBOUNCE_CYCLES(4),
        .ACTIVE_LOW(1)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus),
        .in_port(in_port)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_failed++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and land 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Zero-wait-state read: readdata is combinational, no clock consumed.
    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        bus.address    = a;
        #1;
        check(tag, bus.readdata, exp);
        bus.chipselect = 1'b0;
    endtask

    task automatic chk_irq(input logic exp, input string tag);
        check(tag, {31'b0, bus.irq}, {31'b0, exp});
    endtask

    // Write is sampled by the next rising edge; returns 1 ns after it.
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.address    = a;
        bus.writedata  = d;
        tick();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
    endtask

    initial begin
        reset_n        = 1'b0;
        in_port        = 4'hF;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.address    = 2'd0;
        bus.writedata  = '0;

        // Reset state
        tick();
        tick();
        rd(2'd0, 32'h0, "rst_data");
        rd(2'd3, 32'h0, "rst_edge");
        chk_irq(1'b0, "rst_irq");
        reset_n = 1'b1;

        for (int k = 0; k < 20; k++) begin
            tick();
            rd(2'd0, 32'h0, "idle_data");
            rd(2'd1, 32'h0, "idle_mask");
            rd(2'd3, 32'h0, "idle_edge");
            chk_irq(1'b0, "idle_irq");
        end

        // Button 0 press: accepted on the 6th edge, not earlier
        in_port = 4'hE;
        for (int k = 1; k <= 6; k++) begin
            tick();
            rd(2'd0, (k >= 6) ? 32'h1 : 32'h0, "press0_data");
        end
        rd(2'd3, 32'h1, "press0_edge");
        chk_irq(1'b0, "press0_irq_masked");

        // No chipselect -> readdata is 0
        bus.address = 2'd0;
        #1;
        check("nocs_readdata", bus.readdata, 32'h0);

        // Mask with pending edge, then clear
        wr(2'd1, 32'h1);
        chk_irq(1'b1, "mask_irq_on");
        rd(2'd1, 32'h1, "mask_read");
        wr(2'd3, 32'h1);
        chk_irq(1'b0, "clr_irq_off");
        rd(2'd3, 32'h0, "clr_edge");
        rd(2'd2, 32'h0, "reserved");

        // Glitch on button 1 for 3 cycles (button 0 still held)
        in_port = 4'hC;
        tick();
        tick();
        tick();
        in_port = 4'hE;
        for (int k = 0; k < 10; k++) begin
            tick();
            rd(2'd0, 32'h1, "glitch_data");
            rd(2'd3, 32'h0, "glitch_edge");
        end

        // Button 2: software clear on the same edge stable[2] rises
        in_port = 4'hA;
        for (int k = 0; k < 5; k++) tick();
        rd(2'd0, 32'h1, "setwin_pre_data");
        wr(2'd3, 32'h4);
        rd(2'd0, 32'h5, "setwin_data");
        rd(2'd3, 32'h4, "setwin_edge");
        chk_irq(1'b0, "setwin_irq_masked");

        // Mask change with pending edge: irq follows next cycle
        wr(2'd1, 32'h4);
        chk_irq(1'b1, "mask2_irq_on");
        rd(2'd3, 32'h4, "mask2_edge_kept");

        // Held buttons produce no further edges
        wr(2'd3, 32'hF);
        chk_irq(1'b0, "held_irq_clr");
        for (int k = 0; k < 10; k++) tick();
        rd(2'd3, 32'h0, "held_edge");
        rd(2'd0, 32'h5, "held_data");

        // Release everything: releases never set edge bits
        in_port = 4'hF;
        for (int k = 0; k < 8; k++) tick();
        rd(2'd0, 32'h0, "release_data");
        rd(2'd3, 32'h0, "release_edge");

        // Two buttons pressed in the same cycle set together
        in_port = 4'hC;
        for (int k = 0; k < 6; k++) tick();
        rd(2'd0, 32'h3, "multi_data");
        rd(2'd3, 32'h3, "multi_edge");
        in_port = 4'hF;
        wr(2'd3, 32'hF);
        wr(2'd1, 32'h0);
        for (int k = 0; k < 8; k++) tick();
        rd(2'd0, 32'h0, "multi_rel_data");

        // Button 3 accepted, then reset mid-hold
        in_port = 4'h7;
        for (int k = 0; k < 6; k++) tick();
        rd(2'd0, 32'h8, "b3_data");
        rd(2'd3, 32'h8, "b3_edge");
        wr(2'd1, 32'h8);
        chk_irq(1'b1, "b3_irq");
        reset_n = 1'b0;
        #1;
        rd(2'd0, 32'h0, "inrst_data");
        rd(2'd1, 32'h0, "inrst_mask");
        rd(2'd3, 32'h0, "inrst_edge");
        chk_irq(1'b0, "inrst_irq");
        tick();
        tick();
        rd(2'd0, 32'h0, "inrst2_data");
        reset_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            rd(2'd0, (k >= 6) ? 32'h8 : 32'h0, "postrst_data");
            rd(2'd3, (k >= 6) ? 32'h8 : 32'h0, "postrst_edge");
        end
        chk_irq(1'b0, "postrst_irq");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule
